sobel_filter_stream: RTL

- Parametrised 3x3 gradient filter for the emboss/edge pipeline; successor to the fixed 8-bit x-only emboss filter.
- Consumes one 3-pixel column per beat (rows r0 top, r1 mid, r2 bottom) from the line-buffer stage.
- Produces one filtered pixel per beat once a 3-column window is filled, with full valid/ack backpressure.
- Supports x, y, combined-magnitude and passthrough modes, a scaling shift, and line-start windowing.

---
 rtl/sobel_filter_stream.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sobel_filter_stream.sv
// Streaming 3x3 Sobel gradient filter: column window, gradients, magnitude.
// Optional SOBEL_THRESH_EN adds i_thresh and binarises the magnitude output.
module sobel_filter_stream #(
  parameter int DW    = 8,
  parameter int SHIFT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_pixel_1,
  input  logic [DW-1:0] i_pixel_2,
  input  logic [DW-1:0] i_pixel_3,
  input  logic          i_sol,
  input  logic          i_pixel_valid,
  output logic          o_pixel_ack,
  input  logic [1:0]    i_mode,
`ifdef SOBEL_THRESH_EN
  input  logic [DW-1:0] i_thresh,
`endif
  output logic          o_pixel_valid,
  input  logic          i_pixel_ack,
  output logic [DW-1:0] o_pixel
);

  localparam int W = DW + 3;

  localparam logic [1:0] M_GX  = 2'd0;
  localparam logic [1:0] M_GY  = 2'd1;
  localparam logic [1:0] M_SUM = 2'd2;
  localparam logic [1:0] M_CTR = 2'd3;

  typedef struct packed {
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
  } col_t;

  function automatic logic [W-1:0] wsum(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [DW-1:0] c
  );
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  logic advance;
  logic accept;

  assign advance     = !o_pixel_valid || i_pixel_ack;
  assign o_pixel_ack = advance && i_rst_n;
  assign accept      = i_pixel_valid && o_pixel_ack;

  // stage 0: column window
  col_t          c0, c1, c2;
  logic [1:0]    wcnt;
  logic [1:0]    s0_mode;
  logic          s0_valid;
  logic [1:0]    wbase;
  logic [1:0]    wnext;
`ifdef SOBEL_THRESH_EN
  logic [DW-1:0] s0_thr;
`endif

  // i_sol restarts the count before this beat is counted
  always_comb begin
    wbase = i_sol ? 2'd0 : wcnt;
    wnext = (wbase == 2'd2) ? 2'd2 : wbase + 2'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c0       <= '0;
      c1       <= '0;
      c2       <= '0;
      wcnt     <= 2'd0;
      s0_mode  <= 2'd0;
      s0_valid <= 1'b0;
`ifdef SOBEL_THRESH_EN
      s0_thr   <= '0;
`endif
    end else if (advance) begin
      s0_valid <= accept && (wbase == 2'd2);
      if (accept) begin
        c0      <= c1;
        c1      <= c2;
        c2      <= '{r0: i_pixel_1, r1: i_pixel_2, r2: i_pixel_3};
        wcnt    <= wnext;
        s0_mode <= i_mode;
`ifdef SOBEL_THRESH_EN
        s0_thr  <= i_thresh;
`endif
      end
    end
  end

  // stage 1: gradients
  logic signed [W-1:0] gx_d, gy_d;
  logic signed [W-1:0] s1_gx, s1_gy;
  logic [DW-1:0]       s1_ctr;
  logic [1:0]          s1_mode;
  logic                s1_valid;
`ifdef SOBEL_THRESH_EN
  logic [DW-1:0]       s1_thr;
`endif

  always_comb begin
    gx_d = wsum(c2.r0, c2.r1, c2.r2) - wsum(c0.r0, c0.r1, c0.r2);
    gy_d = wsum(c0.r2, c1.r2, c2.r2) - wsum(c0.r0, c1.r0, c2.r0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_gx    <= '0;
      s1_gy    <= '0;
      s1_ctr   <= '0;
      s1_mode  <= 2'd0;
      s1_valid <= 1'b0;
`ifdef SOBEL_THRESH_EN
      s1_thr   <= '0;
`endif
    end else if (advance) begin
      s1_gx    <= gx_d;
      s1_gy    <= gy_d;
      s1_ctr   <= c1.r1;
      s1_mode  <= s0_mode;
      s1_valid <= s0_valid;
`ifdef SOBEL_THRESH_EN
      s1_thr   <= s0_thr;
`endif
    end
  end

  // stage 2: magnitude, scale, saturate
  logic [W-1:0]  ax, ay, mag, shf;
  logic [DW-1:0] sat, res;

  always_comb begin
    ax  = s1_gx[W-1] ? W'(-s1_gx) : W'(s1_gx);
    ay  = s1_gy[W-1] ? W'(-s1_gy) : W'(s1_gy);
    mag = '0;
    unique case (1'b1)
      (s1_mode == M_GX):  mag = ax;
      (s1_mode == M_GY):  mag = ay;
      (s1_mode == M_SUM): mag = ax + ay;
      default:            mag = '0;
    endcase
    shf = mag >> SHIFT;
    sat = (|shf[W-1:DW]) ? {DW{1'b1}} : shf[DW-1:0];
`ifdef SOBEL_THRESH_EN
    res = (sat >= s1_thr) ? {DW{1'b1}} : '0;
`else
    res = sat;
`endif
    if (s1_mode == M_CTR)
      res = s1_ctr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else if (advance) begin
      o_pixel       <= res;
      o_pixel_valid <= s1_valid;
    end
  end

endmodule
